ifu_fetch_queue: RTL
====================

// Module: ifu_fetch_queue
// PURPOSE
//  Circular buffer of fetch groups between ICache/IFU output and decode.
//  One fetch group = {pc, INSTR_PER_FETCH instructions, lane-valid mask}.
//  Decouples ICache hit/miss timing from decode back-pressure.
//  Depth and width come from the IFU_FQ_DEPTH, INSTR_PER_FETCH, ILEN and VLEN fields of cfg_t.
// PARAMETERS
//  DEPTH            8   entries; cfg.IFU_FQ_DEPTH; power of 2, >=2
//  INSTR_PER_FETCH  4   lanes per group; cfg.INSTR_PER_FETCH
//  ILEN             32  instruction width; cfg.ILEN
//  VLEN             32  pc width; cfg.VLEN
// PORTS
//  clk_i        in   1                  clock
//  rst_ni       in   1                  sync reset, active-low
//  flush_i      in   1                  redirect; discard all contents
//  enq_valid_i  in   1                  upstream group valid
//  enq_ready_o  out  1                  queue can accept
//  enq_pc_i     in   VLEN               group start pc
//  enq_instr_i  in   INSTR_PER_FETCH*ILEN  lane i at [i*ILEN +: ILEN]
//  enq_mask_i   in   INSTR_PER_FETCH    lane valid mask
//  deq_valid_o  out  1                  head group valid
//  deq_ready_i  in   1                  decode accepts head
//  deq_pc_o     out  VLEN               head pc
//  deq_instr_o  out  INSTR_PER_FETCH*ILEN  head instructions
//  deq_mask_o   out  INSTR_PER_FETCH    head lane mask
//  count_o      out  $clog2(DEPTH)+1    occupied entries
// BEHAVIOUR
//  - Transfer when valid&ready (both sides). wr_ptr/rd_ptr are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0.
//  - enq_ready_o = (count != DEPTH) & ~flush_i. This signal does not depend on deq_ready_i.
//  - deq_valid_o = (count != 0) & ~flush_i. deq_* data comes from the head entry, read combinationally.
//  - When deq_valid_o=0, deq_pc_o, deq_instr_o and deq_mask_o drive 0.
//  - Enq accepted with enq_mask_i==0: handshake completes; group is not stored; count is unchanged.
//  - Same-cycle enq+deq: count unchanged; both pointers advance.
//  - When full, enq is blocked. When empty, deq is blocked. There is no overflow or underflow path.
//  - flush_i (highest priority): next cycle, ptrs=0 and count=0. Enq and deq in the flush cycle are ignored.
//  - Reset (rst_ni=0 on a clk_i edge): ptrs=0, count=0. Next cycle: deq_valid_o=0, enq_ready_o=1, data outputs 0.
//    Storage contents are not reset.
//  - Reset mid-operation: all contents are lost, same as flush.
//  - Latency: enqueue to deq_valid_o is 1 cycle (without bypass).
//  - Throughput: 1 group per cycle in and 1 group per cycle out.
//  - count_o is registered and equals the number of stored groups.
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined:
//    - When count==0 and ~flush_i, deq_valid_o = enq_valid_i & |enq_mask_i, and deq_* = enq_* combinationally.
//    - If deq_ready_i is high that cycle, the group is consumed and not written; count stays 0.
//    - If deq_ready_i is low, the group is written normally.
//    - enq_ready_o is unchanged.
//  FETCHQ_BYPASS_EN undefined:
//    - No enq->deq combinational path; minimum latency is 1 cycle.
// TESTING
//  1. Reset -> deq_valid_o=0, enq_ready_o=1, count_o=0, deq_pc_o=0.
//  2. Enq pc=0x8000_0000, mask=4'b1111, deq_ready_i=0 -> next cycle deq_valid_o=1, deq_pc_o=0x8000_0000, count_o=1.
//  3. Enq 8 groups (pc 0x100,0x110,...,0x170) with deq_ready_i=0 -> count_o=8, enq_ready_o=0.
//     A 9th enq_valid_i is not accepted.
//     Then deq_ready_i=1 for 8 cycles -> pcs emerge in order; count_o back to 0.
//  4. Steady enq+deq every cycle over 20 groups (ptr wrap) -> count_o stays 1, no loss, strict FIFO order.
//  5. Fill 5 entries, then flush_i=1 together with enq_valid_i=1 -> next cycle count_o=0 and deq_valid_o=0.
//     The enqueued group never appears.
//  6. Empty queue, enq mask=4'b0000 -> accepted, count_o stays 0.
//     With FETCHQ_BYPASS_EN: empty queue, enq pc=0x200 and deq_ready_i=1 -> deq_pc_o=0x200 in the same cycle, count_o stays 0.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: circular buffer of fetch groups sitting between the
// ICache/IFU output and decode. Each entry holds {pc, instructions, lane mask}.
// Optional build macro: FETCHQ_BYPASS_EN adds a combinational enq->deq path
// used when the queue is empty.
//
// Handshake: a transfer happens on a side when its valid and ready are both
// high at the rising clock edge. enq_ready_o never depends on deq_ready_i,
// and deq_valid_o never waits on deq_ready_i.
module ifu_fetch_queue #(
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned VLEN            = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic                            enq_valid_i,
  output logic                            enq_ready_o,
  input  logic [VLEN-1:0]                 enq_pc_i,
  input  logic [INSTR_PER_FETCH*ILEN-1:0] enq_instr_i,
  input  logic [INSTR_PER_FETCH-1:0]      enq_mask_i,
  output logic                            deq_valid_o,
  input  logic                            deq_ready_i,
  output logic [VLEN-1:0]                 deq_pc_o,
  output logic [INSTR_PER_FETCH*ILEN-1:0] deq_instr_o,
  output logic [INSTR_PER_FETCH-1:0]      deq_mask_o,
  output logic [$clog2(DEPTH):0]          count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned IW    = INSTR_PER_FETCH * ILEN;

  // Entry storage; contents survive reset and flush, only pointers are cleared.
  logic [VLEN-1:0]            pc_mem_q    [DEPTH];
  logic [IW-1:0]              instr_mem_q [DEPTH];
  logic [INSTR_PER_FETCH-1:0] mask_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic head_valid;
  logic full;
  logic bypass_consume;
  logic wr_en;
  logic rd_en;

  assign head_valid  = (count_q != '0);
  assign full        = (count_q == CNT_W'(DEPTH));
  assign enq_ready_o = ~full & ~flush_i;
  assign count_o     = count_q;

  // Head presentation: stored head entry, or the incoming group when bypassing.
  always_comb begin
    deq_valid_o    = head_valid & ~flush_i;
    deq_pc_o       = '0;
    deq_instr_o    = '0;
    deq_mask_o     = '0;
    bypass_consume = 1'b0;
    if (deq_valid_o) begin
      deq_pc_o    = pc_mem_q[rd_ptr_q];
      deq_instr_o = instr_mem_q[rd_ptr_q];
      deq_mask_o  = mask_mem_q[rd_ptr_q];
    end
`ifdef FETCHQ_BYPASS_EN
    if (!head_valid && !flush_i) begin
      deq_valid_o = enq_valid_i & (|enq_mask_i);
      if (deq_valid_o) begin
        deq_pc_o    = enq_pc_i;
        deq_instr_o = enq_instr_i;
        deq_mask_o  = enq_mask_i;
      end
      // A bypassed group taken by decode this cycle is never written.
      bypass_consume = deq_valid_o & deq_ready_i;
    end
`endif
  end

  // Empty-mask groups complete the handshake but are dropped, not stored.
  assign wr_en = enq_valid_i & enq_ready_o & (|enq_mask_i) & ~bypass_consume;
  // Only stored entries pop the read pointer; flush already gates deq_valid_o.
  assign rd_en = deq_valid_o & deq_ready_i & head_valid;

  // Pointer and occupancy next-state; flush wins over any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write at the tail; no reset on the data path.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      pc_mem_q[wr_ptr_q]    <= enq_pc_i;
      instr_mem_q[wr_ptr_q] <= enq_instr_i;
      mask_mem_q[wr_ptr_q]  <= enq_mask_i;
    end
  end

endmodule
